sync_filter_bank: RTL
=====================

SYNC_FILTER_BANK -- requirements
Module: sync_filter_bank

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset; ports are named `clock` and `reset_n`.
REQ-002 Parameter WIDTH SHALL default to 1, range 1..32, and sets the number of independent input channels.
REQ-003 Parameter SYNC_STAGES SHALL default to 3, range 2..5, and sets the synchronizer flop depth per channel.
REQ-004 Parameter FILTER_CYCLES SHALL default to 4, range 1..255, and sets the consecutive-cycle debounce threshold.
REQ-005 Parameter RESET_VAL SHALL default to all-zero, is WIDTH bits wide, and sets the per-channel reset level of all state.
REQ-006 Port `clock` SHALL be an input, 1 bit wide, and is the sole clock; all flops sample on its rising edge.
REQ-007 Port `reset_n` SHALL be an input, 1 bit wide: asynchronous assert, active-low reset.
REQ-008 Port `async_in` SHALL be an input, WIDTH bits wide, carrying asynchronous level inputs.
REQ-009 Port `clr` SHALL be an input, 1 bit wide: synchronous clear of the debounce counters.
REQ-010 Port `sync_out` SHALL be an output, WIDTH bits wide, driven from the last synchronizer stage.
REQ-011 Port `filt_out` SHALL be an output, WIDTH bits wide, carrying the debounced level.
REQ-012 Port `rise` SHALL be an output, WIDTH bits wide: a one-cycle pulse on each 0->1 transition of filt_out.
REQ-013 Port `fall` SHALL be an output, WIDTH bits wide: a one-cycle pulse on each 1->0 transition of filt_out.
REQ-014 Port `any_edge` SHALL be an output, 1 bit wide, equal to the OR-reduction of rise|fall.

Function
REQ-015 Each channel SHALL shift async_in[i] through SYNC_STAGES flops; sync_out[i] is the last stage, giving SYNC_STAGES cycles of latency.
REQ-016 Each channel SHALL hold a counter cnt of width clog2(FILTER_CYCLES+1); cnt SHALL NOT wrap.
REQ-017 Each cycle, per channel: if sync_out==filt_out, cnt<=0; else if cnt==FILTER_CYCLES-1, filt_out<=sync_out and cnt<=0; else cnt<=cnt+1.
REQ-018 filt_out SHALL change only after FILTER_CYCLES consecutive cycles of sync_out differing from it; the total input-to-filt_out latency is SYNC_STAGES+FILTER_CYCLES cycles.
REQ-019 A sync_out excursion shorter than FILTER_CYCLES cycles SHALL leave filt_out unchanged and return cnt to 0.
REQ-020 With FILTER_CYCLES==1, filt_out SHALL follow sync_out with exactly one cycle of delay.
REQ-021 rise and fall SHALL be registered and asserted in the same cycle filt_out takes its new value, for exactly one cycle; they SHALL never both be high on one channel.
REQ-022 clr high SHALL force all cnt to 0 that cycle (precedence over REQ-017), leave filt_out and the sync stages unchanged, and suppress any filt_out update that cycle.
REQ-023 Channels SHALL be fully independent; simultaneous transitions on several channels produce simultaneous pulses.

Reset
REQ-024 With reset_n low, all sync stages and filt_out SHALL equal RESET_VAL, and cnt, rise, fall and any_edge SHALL be 0, asynchronously.
REQ-025 Reset deassertion SHALL be treated as synchronous to clock by the integrator; assertion mid-debounce SHALL abort the count with no pulse.

Configuration
REQ-026 Macro SYNC_FILTER_BANK_FILTER_EN SHALL control the debounce filter: when defined, REQ-016..REQ-022 apply; when undefined, no counters SHALL be built, filt_out SHALL be a one-cycle register of sync_out, rise/fall SHALL derive from that register, and clr SHALL be ignored.

Verification (WIDTH=4, SYNC_STAGES=3, FILTER_CYCLES=4, RESET_VAL=4'b0000, macro defined)
REQ-027 Stimulus: async_in 0->4'b0001 held -> sync_out[0]=1 after 3 cycles, filt_out[0]=1 and rise[0]=1 after 7 cycles, any_edge=1 for one cycle.
REQ-028 Stimulus: filt_out[1]=1, then async_in[1] low for 3 cycles -> filt_out[1] stays 1, no fall pulse, cnt returns to 0.
REQ-029 Stimulus: async_in=4'b1111 applied at once -> rise=4'b1111 in the same single cycle.
REQ-030 Stimulus: differing input 3 cycles, clr pulse, 4 further cycles -> filt_out updates only on the 4th post-clr cycle.
REQ-031 Stimulus: reset_n low mid-count with filt_out=4'b0101 -> all outputs 0 immediately, no pulses after release.
REQ-032 Stimulus: macro undefined, same as REQ-027 -> filt_out[0]=1 and rise[0]=1 after 4 cycles.

Source files
------------

// File: rtl/sync_filter_bank.sv
`default_nettype none
// ============================================================================
// Module      : sync_filter_bank
// Description : Per-channel multi-flop synchronizer, consecutive-cycle
//               debounce filter and registered rise/fall edge pulses.
//               Macro SYNC_FILTER_BANK_FILTER_EN builds the debounce counters;
//               without it filt_out is a plain one-cycle register of sync_out.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_filter_bank #(
    parameter int             WIDTH         = 1,
    parameter int             SYNC_STAGES   = 3,
    parameter int             FILTER_CYCLES = 4,
    parameter logic [WIDTH-1:0] RESET_VAL   = '0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] async_in,
    input  logic             clr,
    output logic [WIDTH-1:0] sync_out,
    output logic [WIDTH-1:0] filt_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             any_edge
);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= RESET_VAL;
            end
        end else begin
            sync_q[0] <= async_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef SYNC_FILTER_BANK_FILTER_EN
    localparam int               CNT_W    = $clog2(FILTER_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

    logic [CNT_W-1:0] cnt [WIDTH];

    // Counter saturates implicitly: it is cleared on reaching CNT_LAST.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            filt_out <= RESET_VAL;
            rise     <= '0;
            fall     <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            rise <= '0;
            fall <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                if (clr) begin
                    cnt[i] <= '0;
                end else if (sync_out[i] == filt_out[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    filt_out[i] <= sync_out[i];
                    rise[i]     <= sync_out[i];
                    fall[i]     <= ~sync_out[i];
                    cnt[i]      <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end
`else
    logic unused_clr;
    assign unused_clr = clr;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            filt_out <= RESET_VAL;
            rise     <= '0;
            fall     <= '0;
        end else begin
            filt_out <= sync_out;
            rise     <= sync_out & ~filt_out;
            fall     <= ~sync_out & filt_out;
        end
    end
`endif

    assign any_edge = |(rise | fall);

endmodule
`default_nettype wire
